// File: rtl/rgb_palette_pkg.sv
// Shared types and helpers for the writable RGB colour lookup table.
package rgb_palette_pkg;

  localparam int NUM_CH   = 3;
  localparam int MAX_CH_W = 32;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  // Packed {R,G,B} at channel width ch_w; callers size-cast to their width.
  function automatic logic [NUM_CH*MAX_CH_W-1:0] default_colour(
    input int unsigned idx,
    input int unsigned ch_w
  );
    logic [NUM_CH*MAX_CH_W-1:0] ones;
    logic [NUM_CH*MAX_CH_W-1:0] word;
    ones = '0;
    for (int unsigned k = 0; k < MAX_CH_W; k++)
      if (k < ch_w) ones[k] = 1'b1;
    word = '0;
    if (idx[2]) word = word | (ones << (2 * ch_w));
    if (idx[1]) word = word | (ones << ch_w);
    if (idx[0]) word = word | ones;
    return word;
  endfunction

endpackage

// File: rtl/rgb_palette_ram.sv
// Simple dual-port synchronous RAM with write-first read bypass.
// Registered read port, no reset on storage so it maps onto block RAM.
module rgb_palette_ram #(
  parameter int IDX_W = 3,
  parameter int DW    = 24
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [DW-1:0]    wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [DW-1:0]    q
);

  logic [DW-1:0] mem [1<<IDX_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= (we && waddr == raddr) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/rgb_palette.sv
// Writable colour LUT: self-loads the 8-colour palette, pipelined reads.
// RGB_PALETTE_BRIGHTNESS_EN adds a brightness scaling stage (latency 3).
import rgb_palette_pkg::*;

module rgb_palette #(
  parameter int IDX_W = 3,
  parameter int CH_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   ready,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [NUM_CH*CH_W-1:0] wr_rgb,
  input  logic                   enable,
  input  logic [IDX_W-1:0]       colour,
  output logic [NUM_CH*CH_W-1:0] rgb,
  output logic                   rgb_valid
`ifdef RGB_PALETTE_BRIGHTNESS_EN
  ,
  input  logic [CH_W-1:0]        brightness
`endif
);

  localparam int DW    = NUM_CH * CH_W;
  localparam int DEPTH = 1 << IDX_W;

  state_t           state;
  logic [IDX_W-1:0] cnt;

  logic             ram_we;
  logic [IDX_W-1:0] ram_waddr;
  logic [DW-1:0]    ram_wdata;
  logic [DW-1:0]    ram_q;
  logic             rd_en;

  logic             v0;
  logic             v1;
  logic [DW-1:0]    d1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      unique case (state)
        ST_INIT: begin
          cnt <= cnt + IDX_W'(1);
          if (cnt == IDX_W'(DEPTH - 1)) begin
            state <= ST_READY;
            ready <= 1'b1;
          end
        end
        ST_READY: ;
      endcase
    end
  end

  // Init load owns the write port until the palette is complete.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_idx;
    ram_wdata = wr_rgb;
    if (!rst) begin
      if (state == ST_INIT) begin
        ram_we    = 1'b1;
        ram_waddr = cnt;
        ram_wdata = DW'(default_colour(32'(cnt), CH_W));
      end else begin
        ram_we = wr_en;
      end
    end
  end

  assign rd_en = enable & ready & ~rst;

  rgb_palette_ram #(
    .IDX_W(IDX_W),
    .DW   (DW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (rd_en),
    .raddr(colour),
    .q    (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
    end else begin
      v0 <= rd_en;
      v1 <= v0;
    end
  end

  always_ff @(posedge clk) d1 <= ram_q;

`ifdef RGB_PALETTE_BRIGHTNESS_EN
  logic             v2;
  logic [DW-1:0]    d2;
  logic [DW-1:0]    scaled;
  logic [2*CH_W:0]  opa;
  logic [2*CH_W:0]  opb;

  always_ff @(posedge clk) begin
    if (rst) v2 <= 1'b0;
    else     v2 <= v1;
  end

  always_ff @(posedge clk) d2 <= d1;

  // brightness+1 keeps all-ones an exact identity after the >> CH_W.
  always_comb begin
    scaled = '0;
    opa    = '0;
    opb    = {{(CH_W+1){1'b0}}, brightness} + {{(2*CH_W){1'b0}}, 1'b1};
    for (int c = 0; c < NUM_CH; c++) begin
      opa = {{(CH_W+1){1'b0}}, d2[c*CH_W +: CH_W]};
      scaled[c*CH_W +: CH_W] = CH_W'((opa * opb) >> CH_W);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb       <= '0;
      rgb_valid <= 1'b0;
    end else begin
      rgb_valid <= v2;
      if (v2) rgb <= scaled;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb       <= '0;
      rgb_valid <= 1'b0;
    end else begin
      rgb_valid <= v1;
      if (v1) rgb <= d1;
    end
  end
`endif

endmodule

// File: tb/tb_rgb_palette.sv
// Directed plus random bench for rgb_palette against a cycle model.
module tb_rgb_palette;

`ifdef RGB_PALETTE_BRIGHTNESS_EN
  localparam int LAT = 3;
  logic [7:0] brightness;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        rst;
  logic        ready;
  logic        wr_en;
  logic [2:0]  wr_idx;
  logic [23:0] wr_rgb;
  logic        enable;
  logic [2:0]  colour;
  logic [23:0] rgb;
  logic        rgb_valid;

  rgb_palette #(.IDX_W(3), .CH_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_rgb   (wr_rgb),
    .enable   (enable),
    .colour   (colour),
    .rgb      (rgb),
    .rgb_valid(rgb_valid)
`ifdef RGB_PALETTE_BRIGHTNESS_EN
    ,
    .brightness(brightness)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [23:0] mem [8];
  int          init_cnt;
  bit          m_ready;
  bit          pv [LAT];
  logic [23:0] pd [LAT];
  bit          m_valid;
  logic [23:0] m_rgb;
  logic [23:0] got [$];
  logic [23:0] exp_q [$];

  function automatic logic [23:0] dflt(input int i);
    logic [23:0] w;
    w = 24'h0;
    if ((i / 4) % 2 == 1) w = w + 24'hFF0000;
    if ((i / 2) % 2 == 1) w = w + 24'h00FF00;
    if (i % 2 == 1)       w = w + 24'h0000FF;
    return w;
  endfunction

  function automatic logic [23:0] scale(input logic [23:0] w, input int b);
    int r, g, bl;
    r  = (int'(w[23:16]) * (b + 1)) / 256;
    g  = (int'(w[15:8])  * (b + 1)) / 256;
    bl = (int'(w[7:0])   * (b + 1)) / 256;
    return {8'(r), 8'(g), 8'(bl)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    int b;
    @(posedge clk);
`ifdef RGB_PALETTE_BRIGHTNESS_EN
    b = int'(brightness);
`else
    b = 255;
`endif
    if (rst) begin
      m_ready  = 0;
      init_cnt = 0;
      m_valid  = 0;
      m_rgb    = 24'h0;
      for (int k = 0; k < LAT; k++) pv[k] = 0;
      for (int i = 0; i < 8; i++) mem[i] = dflt(i);
    end else begin
      m_valid = pv[LAT-1];
      if (m_valid) m_rgb = scale(pd[LAT-1], b);
      for (int k = LAT - 1; k > 0; k--) begin
        pv[k] = pv[k-1];
        pd[k] = pd[k-1];
      end
      if (m_ready && wr_en) mem[wr_idx] = wr_rgb;
      pv[0] = m_ready && enable;
      pd[0] = mem[colour];
      if (!m_ready) begin
        init_cnt++;
        if (init_cnt == 8) m_ready = 1;
      end
    end
    #1;
    chk("ready", 32'(ready), 32'(m_ready));
    chk("rgb_valid", 32'(rgb_valid), 32'(m_valid));
    chk("rgb", 32'(rgb), 32'(m_rgb));
    if (rgb_valid) got.push_back(rgb);
  endtask

  task automatic step(input bit e, input int c, input bit w, input int wi,
                      input logic [23:0] wd, input bit r);
    enable = e;
    colour = 3'(c);
    wr_en  = w;
    wr_idx = 3'(wi);
    wr_rgb = wd;
    rst    = r;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 24'h0, 0);
  endtask

  task automatic check_seq(input string tag);
    chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk(tag, 32'(got[i]), 32'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    init_cnt = 0;
    m_ready  = 0;
    m_valid  = 0;
    m_rgb    = 24'h0;
    for (int k = 0; k < LAT; k++) begin
      pv[k] = 0;
      pd[k] = 24'h0;
    end
`ifdef RGB_PALETTE_BRIGHTNESS_EN
    brightness = 8'hFF;
`endif
    step(0, 0, 0, 0, 24'h0, 1);
    step(0, 0, 0, 0, 24'h0, 1);

    // Requests during the load must be ignored.
    for (int i = 0; i < 8; i++) step(1, 6, 1, 6, 24'h000000, 0);
    chk("ready_after_8", 32'(ready), 32'd1);
    idle(LAT + 1);
    chk("no_valid_from_init", 32'(got.size()), 32'd0);
    got.delete();

    for (int i = 0; i < 8; i++) step(1, i, 0, 0, 24'h0, 0);
    idle(LAT);
    exp_q = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
              24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};
    check_seq("defaults");

    step(0, 0, 1, 3, 24'h123456, 0);
    step(1, 3, 0, 0, 24'h0, 0);
    step(1, 2, 0, 0, 24'h0, 0);
    idle(LAT);
    exp_q = '{24'h123456, 24'h00FF00};
    check_seq("write_read");

    step(1, 5, 1, 5, 24'hABCDEF, 0);
    idle(LAT);
    exp_q = '{24'hABCDEF};
    check_seq("collision");

    step(0, 0, 0, 0, 24'h0, 1);
    idle(3);
    step(0, 0, 0, 0, 24'h0, 1);
    idle(7);
    chk("ready_low_7", 32'(ready), 32'd0);
    idle(1);
    chk("ready_restart", 32'(ready), 32'd1);

    step(0, 0, 1, 3, 24'h123456, 0);
    step(0, 0, 0, 0, 24'h0, 1);
    idle(8);
    step(1, 3, 0, 0, 24'h0, 0);
    idle(LAT);
    exp_q = '{24'h00FFFF};
    check_seq("reset_restores");

    step(1, 1, 0, 0, 24'h0, 0);
    step(1, 2, 0, 0, 24'h0, 0);
    step(0, 0, 0, 0, 24'h0, 1);
    idle(LAT + 9);
    chk("inflight_aborted", 32'(got.size()), 32'd0);
    got.delete();

`ifdef RGB_PALETTE_BRIGHTNESS_EN
    brightness = 8'h7F;
    step(1, 7, 0, 0, 24'h0, 0);
    idle(LAT);
    exp_q = '{24'h7F7F7F};
    check_seq("bright_7f");
    brightness = 8'hFF;
    step(1, 7, 0, 0, 24'h0, 0);
    idle(LAT);
    exp_q = '{24'hFFFFFF};
    check_seq("bright_ff");
`endif

    for (int i = 0; i < 400; i++) begin
`ifdef RGB_PALETTE_BRIGHTNESS_EN
      brightness = 8'($urandom);
`endif
      step(($urandom % 10) < 7, int'($urandom_range(0, 7)),
           ($urandom % 10) < 4, int'($urandom_range(0, 7)),
           24'($urandom), ($urandom % 60) == 0);
    end
    got.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rgb_palette.md
# rgb_palette

Parametrised, writable colour lookup table for the display datapath: maps an IDX_W-bit colour index to a 3-channel RGB word of CH_W bits per channel. After reset it self-loads the standard 8-colour palette, then serves one pipelined read per cycle. Palette entries can be rewritten at run time through a write port. Optionally, a brightness-scaling stage is compiled in on the output. It is the successor to the fixed 8-entry, 24-bit read-only colour converter.

## Interface
- IDX_W, 3, index width; DEPTH = 2^IDX_W entries
- CH_W, 8, bits per colour channel; RGB word = 3*CH_W bits, packed {R,G,B}
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ready  out  1  high once initial palette load is complete
- wr_en  in  1  write strobe; ignored while ready=0
- wr_idx  in  IDX_W  entry to write
- wr_rgb  in  3*CH_W  data to write
- enable  in  1  read request; ignored while ready=0
- colour  in  IDX_W  index to read
- rgb  out  3*CH_W  looked-up colour
- rgb_valid  out  1  one-cycle strobe, rgb carries the result of a read
- brightness  in  CH_W  output scale; present only with RGB_PALETTE_BRIGHTNESS_EN

## Operation
- FSM states: ST_INIT, ST_READY. rst forces ST_INIT with init counter = 0.
- ST_INIT: one entry written per cycle, entry i = default(i); counter wraps DEPTH-1 -> ST_READY. Load takes DEPTH cycles.
- default(i): R = all-ones if i[2], G = all-ones if i[1], B = all-ones if i[0], else zero. Entries >= 8 repeat modulo 8. For CH_W=8 this gives 0 black 000000, 1 blue 0000FF, 2 green 00FF00, 3 cyan 00FFFF, 4 red FF0000, 5 magenta FF00FF, 6 yellow FFFF00, 7 white FFFFFF.
- ST_READY: wr_en writes wr_rgb to wr_idx. enable reads colour. Both may occur in the same cycle.
- Same-cycle read and write to the same index: write-first, so the read returns wr_rgb. Different indices: independent.
- Reads issued in ST_INIT produce no rgb_valid. Writes issued in ST_INIT are dropped.
- rst at any time, including mid-init or with reads in flight:
  - aborts in-flight reads (no rgb_valid);
  - restarts the load;
  - restores every entry to its default.

## Timing
- Reset values: ready=0, rgb=0, rgb_valid=0, FSM=ST_INIT.
- ready rises on the DEPTH-th rising edge after the cycle in which rst is sampled low.
- Read latency is 2 cycles: enable sampled at edge N; rgb and rgb_valid update at edge N+2.
- Throughput is 1 read per cycle; continuous enable yields continuous rgb_valid.
- rgb holds its last value when rgb_valid=0.
- A write at edge N is visible to a read sampled at edge N (write-first) and to all later reads.

## Configuration
- RGB_PALETTE_BRIGHTNESS_EN defined:
  - adds the brightness port and one register stage, so read latency is 3;
  - each channel is scaled as out = (ch * (brightness + 1)) >> CH_W, computed in 2*CH_W+1 bits and truncated to CH_W;
  - brightness = all-ones is identity;
  - brightness is sampled with the data in the scaling stage, not at request time;
  - rgb_valid is delayed to match.
- Undefined: no brightness port, no scaling, latency 2.

## Structure
- rgb_palette_pkg holds:
  - NUM_CH = 3;
  - state enum {ST_INIT, ST_READY};
  - function default_colour(idx, CH_W) returning the packed default word.
- Sub-module rgb_palette_ram: simple dual-port synchronous RAM (1 write port, 1 read port, write-first bypass), parametrised on IDX_W and data width, inferable as block RAM.
- The top level holds the FSM/init counter, write mux (init vs user), valid pipeline and optional scaling stage.

## Test plan
- Defaults: rst 2 cycles, release → ready rises on the 8th edge. Then read indices 0..7 back-to-back → rgb sequence 000000, 0000FF, 00FF00, 00FFFF, FF0000, FF00FF, FFFF00, FFFFFF, each with rgb_valid, 2 cycles after its request.
- Write then read: write idx 3 = 123456, read idx 3 next cycle → 123456. Read idx 2 → still 00FF00.
- Write-first collision: same cycle, write idx 5 = ABCDEF and read idx 5 → ABCDEF, 2 cycles later.
- Requests during init: enable and wr_en asserted during the load → no rgb_valid. After ready, idx 6 reads FFFF00 (write dropped).
- Reset mid-operation:
  - rst asserted on the 4th init cycle → ready stays 0, load restarts, ready rises 8 edges after release.
  - rst after writing idx 3 = 123456 → idx 3 reads back 00FFFF.
  - rst with 2 reads in flight → no rgb_valid.
- Macro defined, brightness = 7F:
  - read idx 7 → 7F7F7F with rgb_valid 3 cycles after the request;
  - brightness = FF → FFFFFF.
